// File: rtl/coin_acceptor_if.sv
// Coin-chute bundle: raw sensors and enable in, clean coin/reject pulses and busy out.
// The acceptor is the master and produces the pulses; a coin counter or bench is the slave.
interface coin_if;
  logic quarter_sense;
  logic dime_sense;
  logic nickel_sense;
  logic enable;
  logic quarters;
  logic dimes;
  logic nickels;
  logic reject;
  logic busy;

  modport master (
    input  quarter_sense, dime_sense, nickel_sense, enable,
    output quarters, dimes, nickels, reject, busy
  );

  modport slave (
    output quarter_sense, dime_sense, nickel_sense, enable,
    input  quarters, dimes, nickels, reject, busy
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces three chute sensors, then emits
// one single-cycle coin or reject pulse per insertion, followed by release wait and lockout.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 8
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  coin_if.master    bus
);

  localparam int unsigned MAX_CYCLES =
    (DEBOUNCE_CYCLES > LOCKOUT_CYCLES) ? DEBOUNCE_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_EMIT     = 3'd2,
    ST_REJECT   = 3'd3,
    ST_RELEASE  = 3'd4,
    ST_LOCKOUT  = 3'd5
  } state_e;

  // Sensor vectors are ordered {quarter, dime, nickel} throughout.
  logic [2:0]       raw_s;
  logic [2:0]       s1_q;
  logic [2:0]       s2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       coin_q, coin_d;

  function automatic logic multi_hot(input logic [2:0] v);
    return (v & (v - 3'd1)) != 3'd0;
  endfunction

  assign raw_s = {bus.quarter_sense, bus.dime_sense, bus.nickel_sense};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 3'b000;
      s2_q <= 3'b000;
    end else begin
      s1_q <= raw_s;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      coin_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coin_q  <= coin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    coin_d  = coin_q;
    case (state_q)
      ST_IDLE: begin
        if (multi_hot(s2_q)) begin
          state_d = ST_REJECT;
          cnt_d   = CNT_ZERO;
        end else if (s2_q != 3'b000) begin
          coin_d  = s2_q;
          cnt_d   = CNT_ONE;
          state_d = ST_DEBOUNCE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DEBOUNCE: begin
        // A foreign sensor outranks a dropout of the latched one.
        if ((s2_q & ~coin_q) != 3'b000) begin
          state_d = ST_REJECT;
          cnt_d   = CNT_ZERO;
        end else if ((s2_q & coin_q) == 3'b000) begin
          coin_d  = 3'b000;
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_EMIT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_EMIT, ST_REJECT: begin
        state_d = ST_RELEASE;
        cnt_d   = CNT_ZERO;
      end
      ST_RELEASE: begin
        if (s2_q != 3'b000) begin
          cnt_d = CNT_ZERO;
        end else if (cnt_q == REL_LAST) begin
          state_d = ST_LOCKOUT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LOCKOUT: begin
        if (cnt_q == LOCK_LAST) begin
          state_d = ST_IDLE;
          coin_d  = 3'b000;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        coin_d  = 3'b000;
      end
    endcase
  end

  // Pulses decode from registered state; only enable is looked at live, in EMIT.
  always_comb begin
    bus.quarters = 1'b0;
    bus.dimes    = 1'b0;
    bus.nickels  = 1'b0;
    bus.reject   = 1'b0;
    bus.busy     = (state_q != ST_IDLE);
    case (state_q)
      ST_EMIT: begin
        if (bus.enable) begin
          bus.quarters = coin_q[2];
          bus.dimes    = coin_q[1];
          bus.nickels  = coin_q[0];
        end else begin
          bus.reject = 1'b1;
        end
      end
      ST_REJECT: begin
        bus.reject = 1'b1;
      end
      default: begin
        bus.reject = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor (D=4, L=8): edge-accurate checks of pulses, busy and reset.
module tb_coin_acceptor;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  coin_if bus();

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_checks   = 0;
  int n_fail     = 0;
  int q_cnt      = 0;
  int d_cnt      = 0;
  int n_cnt      = 0;
  int r_cnt      = 0;
  int mutex_viol = 0;
  int q0, d0, n0, r0;

  // Pulse tallies and exclusivity watch, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.quarters) q_cnt++;
    if (bus.dimes)    d_cnt++;
    if (bus.nickels)  n_cnt++;
    if (bus.reject)   r_cnt++;
    if ($countones({bus.quarters, bus.dimes, bus.nickels, bus.reject}) > 1) mutex_viol++;
  end

  function automatic logic [4:0] outs();
    return {bus.busy, bus.quarters, bus.dimes, bus.nickels, bus.reject};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mark();
    q0 = q_cnt; d0 = d_cnt; n0 = n_cnt; r0 = r_cnt;
  endtask

  // outs() layout: {busy, quarters, dimes, nickels, reject}
  initial begin
    rst_n             = 1'b0;
    bus.quarter_sense = 1'b0;
    bus.dime_sense    = 1'b0;
    bus.nickel_sense  = 1'b0;
    bus.enable        = 1'b1;
    ticks(3);
    check("reset_outputs", {27'd0, outs()}, 32'h00);
    rst_n = 1'b1;
    ticks(2);
    check("idle_outputs", {27'd0, outs()}, 32'h00);

    // Clean quarter; after each ticks() we sit just past the named edge.
    mark();
    bus.quarter_sense = 1'b1;
    ticks(2);
    check("quarter_busy_e1", {31'd0, bus.busy}, 32'd0);
    ticks(1);
    check("quarter_busy_e2", {31'd0, bus.busy}, 32'd1);
    ticks(3);
    check("quarter_e5", {27'd0, outs()}, 32'h10);
    ticks(1);
    check("quarter_e6", {27'd0, outs()}, 32'h18);
    ticks(1);
    check("quarter_e7", {27'd0, outs()}, 32'h10);
    ticks(12);
    bus.quarter_sense = 1'b0;
    ticks(13);
    check("quarter_busy_e32", {31'd0, bus.busy}, 32'd1);
    ticks(1);
    check("quarter_busy_e33", {31'd0, bus.busy}, 32'd0);
    check("quarter_count", q_cnt - q0, 32'd1);
    check("quarter_no_reject", r_cnt - r0, 32'd0);

    // Glitch: four raw samples only.
    mark();
    bus.dime_sense = 1'b1;
    ticks(4);
    bus.dime_sense = 1'b0;
    check("glitch_busy_e3", {31'd0, bus.busy}, 32'd1);
    ticks(2);
    check("glitch_busy_e5", {31'd0, bus.busy}, 32'd1);
    ticks(1);
    check("glitch_idle_e6", {27'd0, outs()}, 32'h00);
    ticks(4);
    check("glitch_no_dime", d_cnt - d0, 32'd0);
    check("glitch_no_reject", r_cnt - r0, 32'd0);

    // Double coin: quarter and nickel on the same edge.
    mark();
    bus.quarter_sense = 1'b1;
    bus.nickel_sense  = 1'b1;
    ticks(3);
    check("double_reject_e2", {27'd0, outs()}, 32'h11);
    ticks(1);
    check("double_e3", {27'd0, outs()}, 32'h10);
    ticks(2);
    bus.quarter_sense = 1'b0;
    bus.nickel_sense  = 1'b0;
    ticks(13);
    check("double_busy_e18", {31'd0, bus.busy}, 32'd1);
    ticks(1);
    check("double_busy_e19", {31'd0, bus.busy}, 32'd0);
    check("double_reject_count", r_cnt - r0, 32'd1);
    check("double_no_coin", (q_cnt - q0) + (n_cnt - n0), 32'd0);

    // Disabled: valid nickel becomes a reject with the same timing.
    mark();
    bus.enable       = 1'b0;
    bus.nickel_sense = 1'b1;
    ticks(6);
    check("disabled_e5", {27'd0, outs()}, 32'h10);
    ticks(1);
    check("disabled_e6", {27'd0, outs()}, 32'h11);
    ticks(1);
    check("disabled_e7", {27'd0, outs()}, 32'h10);
    ticks(2);
    bus.nickel_sense = 1'b0;
    ticks(13);
    check("disabled_busy_e22", {31'd0, bus.busy}, 32'd1);
    ticks(1);
    check("disabled_busy_e23", {31'd0, bus.busy}, 32'd0);
    bus.enable = 1'b1;
    check("disabled_no_nickel", n_cnt - n0, 32'd0);
    check("disabled_reject_count", r_cnt - r0, 32'd1);

    // Bounce during release restarts the release count.
    mark();
    bus.dime_sense = 1'b1;
    ticks(7);
    check("bounce_dime_e6", {27'd0, outs()}, 32'h14);
    ticks(1);
    bus.dime_sense = 1'b0;
    ticks(1);
    bus.dime_sense = 1'b1;
    ticks(1);
    bus.dime_sense = 1'b0;
    ticks(1);
    bus.dime_sense = 1'b1;
    ticks(1);
    bus.dime_sense = 1'b0;
    ticks(13);
    check("bounce_busy_e24", {31'd0, bus.busy}, 32'd1);
    ticks(1);
    check("bounce_busy_e25", {31'd0, bus.busy}, 32'd0);
    check("bounce_dime_count", d_cnt - d0, 32'd1);
    check("bounce_no_reject", r_cnt - r0, 32'd0);

    // Async reset in DEBOUNCE, sensor held through it.
    mark();
    bus.quarter_sense = 1'b1;
    ticks(4);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_immediate", {27'd0, outs()}, 32'h00);
    @(posedge clk);
    #1;
    check("reset_held", {27'd0, outs()}, 32'h00);
    rst_n = 1'b1;
    ticks(6);
    check("post_reset_p5", {27'd0, outs()}, 32'h10);
    ticks(1);
    check("post_reset_p6", {27'd0, outs()}, 32'h18);
    ticks(1);
    bus.quarter_sense = 1'b0;
    ticks(14);
    check("post_reset_idle", {31'd0, bus.busy}, 32'd0);
    check("post_reset_quarter_count", q_cnt - q0, 32'd1);

    check("mutual_exclusion", mutex_viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
